// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide sequencer.
//   - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
//   - sequencer state type
//   - iteration counter width
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'd0;
   localparam logic [1:0] OP_MULTU = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;
   localparam logic [1:0] OP_DIVU  = 2'd3;

   // Wide enough to hold ITER-1 for the default 32-bit datapath.
   localparam int ITER_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the execute stage and muldiv_seq.
//   master (pipeline): start, op, src1, src2, flush, hi_we, lo_we, wdata
//   slave  (muldiv_seq): busy, done, hi, lo
interface muldiv_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] src1;
   logic [WIDTH-1:0] src2;
   logic             flush;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, src1, src2, flush, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, src1, src2, flush, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the sequencer datapath.
//   is_div=0: shift-add multiply step on {hi_in, lo_in} (lo_in holds the
//             remaining multiplier bits, m is the multiplicand).
//   is_div=1: restoring divide step (hi_in is the partial remainder, lo_in
//             shifts the dividend out and the quotient in, m is the divisor).
// Ports: is_div, hi_in, lo_in, m -> hi_out, lo_out
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH:0]   hi_in,
   input  logic [WIDTH-1:0] lo_in,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH:0]   hi_out,
   output logic [WIDTH-1:0] lo_out
);

   logic [WIDTH:0] m_ext;
   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;

   always_comb begin
      m_ext   = {1'b0, m};
      sum     = hi_in + (lo_in[0] ? m_ext : '0);
      shifted = {hi_in[WIDTH-1:0], lo_in[WIDTH-1]};
      hi_out  = '0;
      lo_out  = '0;
      if (is_div) begin
         if (shifted >= m_ext) begin
            hi_out = shifted - m_ext;
            lo_out = {lo_in[WIDTH-2:0], 1'b1};
         end else begin
            hi_out = shifted;
            lo_out = {lo_in[WIDTH-2:0], 1'b0};
         end
      end else begin
         // sum keeps its carry in the top bit; the shift brings it back down.
         hi_out = {1'b0, sum[WIDTH:1]};
         lo_out = {sum[0], lo_in[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO registers.
// Ports: clk, resetn (async, active low), bus (muldiv_if.slave:
//        start/op/src1/src2/flush/hi_we/lo_we/wdata in; busy/done/hi/lo out).
// Optional build macro MULDIV_FAST_MUL_EN: multiply done by a native
// multiplier in a single CALC cycle; divide stays iterative.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO accepted
// CALC  | one iteration per cycle on operand magnitudes
// FIX   | sign correction, result written into HI/LO on exit
// DONE  | done pulse; may re-issue on start; MTHI/MTLO accepted
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic     clk,
   input  logic     resetn,
   muldiv_if.slave  bus
);

   localparam logic [ITER_W-1:0] LAST = ITER_W'(ITER - 1);

   state_t             state, state_next;
   logic [ITER_W-1:0]  cnt;
   logic               is_div;
   logic               neg_q, neg_r;
   logic [WIDTH:0]     hi_w;
   logic [WIDTH-1:0]   lo_w, m_w;
   logic [WIDTH:0]     step_hi;
   logic [WIDTH-1:0]   step_lo;
   logic [WIDTH-1:0]   hi_q, lo_q;

   logic               req_div, s1_neg, s2_neg, div_zero, can_start, busy;
   logic [WIDTH-1:0]   abs1, abs2;
   logic [2*WIDTH-1:0] prod, prod_neg;
   logic [WIDTH-1:0]   res_hi, res_lo;

   assign req_div   = bus.op[1];
   assign s1_neg    = ~bus.op[0] & bus.src1[WIDTH-1];
   assign s2_neg    = ~bus.op[0] & bus.src2[WIDTH-1];
   assign abs1      = s1_neg ? -bus.src1 : bus.src1;
   assign abs2      = s2_neg ? -bus.src2 : bus.src2;
   assign div_zero  = req_div & (bus.src2 == '0);
   assign can_start = bus.start & ((state == IDLE) | (state == DONE));
   assign busy      = (state == CALC) | (state == FIX);

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div (is_div),
      .hi_in  (hi_w),
      .lo_in  (lo_w),
      .m      (m_w),
      .hi_out (step_hi),
      .lo_out (step_lo)
   );

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] m_ext, lo_ext, fast_prod;
   assign m_ext     = {{WIDTH{1'b0}}, m_w};
   assign lo_ext    = {{WIDTH{1'b0}}, lo_w};
   assign fast_prod = m_ext * lo_ext;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (bus.flush) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) state_next = div_zero ? DONE : CALC;
               else           state_next = IDLE;
            end
            CALC: begin
`ifdef MULDIV_FAST_MUL_EN
               if (!is_div || cnt == LAST) state_next = FIX;
`else
               if (cnt == LAST) state_next = FIX;
`endif
            end
            FIX:     state_next = DONE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt    <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         hi_w   <= '0;
         lo_w   <= '0;
         m_w    <= '0;
      end else if (can_start && !bus.flush) begin
         cnt    <= '0;
         is_div <= req_div;
         neg_q  <= s1_neg ^ s2_neg;
         neg_r  <= s1_neg;
         hi_w   <= '0;
         // Divide shifts the dividend through lo; multiply shifts the multiplier.
         lo_w   <= req_div ? abs1 : abs2;
         m_w    <= req_div ? abs2 : abs1;
      end else if (state == CALC) begin
         cnt <= cnt + 1'b1;
`ifdef MULDIV_FAST_MUL_EN
         if (!is_div) begin
            hi_w <= {1'b0, fast_prod[2*WIDTH-1:WIDTH]};
            lo_w <= fast_prod[WIDTH-1:0];
         end else begin
            hi_w <= step_hi;
            lo_w <= step_lo;
         end
`else
         hi_w <= step_hi;
         lo_w <= step_lo;
`endif
      end
   end

   always_comb begin
      prod     = {hi_w[WIDTH-1:0], lo_w};
      prod_neg = -prod;
      res_hi   = hi_w[WIDTH-1:0];
      res_lo   = lo_w;
      if (is_div) begin
         if (neg_q) res_lo = -lo_w;
         if (neg_r) res_hi = -hi_w[WIDTH-1:0];
      end else if (neg_q) begin
         res_hi = prod_neg[2*WIDTH-1:WIDTH];
         res_lo = prod_neg[WIDTH-1:0];
      end
   end

   // A result landing on the same edge as an MT write takes priority; an MT
   // write during DONE lands one edge after the result and so overrides it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (!bus.flush && state == FIX) begin
         hi_q <= res_hi;
         lo_q <= res_lo;
      end else if (!bus.flush && can_start && div_zero) begin
         hi_q <= bus.src1;
         lo_q <= '1;
      end else if (!busy) begin
         if (bus.hi_we) hi_q <= bus.wdata;
         if (bus.lo_we) lo_q <= bus.wdata;
      end
   end

   assign bus.busy = busy;
   assign bus.done = (state == DONE);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;
   import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT     = 3;
   localparam int MUL_BUSY    = 2;
   localparam int FLUSH_TICKS = 0;
`else
   localparam int MUL_LAT     = 34;
   localparam int MUL_BUSY    = 33;
   localparam int FLUSH_TICKS = 9;
`endif
   localparam int DIV_LAT = 34;

   logic clk;
   logic resetn;
   int   tests;
   int   fails;
   int   lat;
   int   bc;
   int   dcnt;

   muldiv_if #(.WIDTH(32)) bus ();

   muldiv_seq #(.WIDTH(32), .ITER(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op    = o;
      bus.src1  = a;
      bus.src2  = b;
   endtask

   // Called right after the start edge; lat counts edges from the start edge
   // up to and including the one after which done is seen.
   task automatic wait_rest(output int l, output int b);
      l = 1;
      b = 0;
      while (!bus.done && l < 200) begin
         if (bus.busy) b++;
         tick();
         l++;
      end
   endtask

   task automatic wait_done(output int l, output int b);
      tick();
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      wait_rest(l, b);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      resetn    = 1'b0;
      bus.start = 1'b0;
      bus.op    = OP_MULT;
      bus.src1  = '0;
      bus.src2  = '0;
      bus.flush = 1'b0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wdata = '0;
      #12;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_hi", 64'(bus.hi), 64'd0);
      chk("rst_lo", 64'(bus.lo), 64'd0);
      tick();
      resetn = 1'b1;
      tick();

      // MULT -3 * 5 = -15
      issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
      wait_done(lat, bc);
      chk("mult_lat", 64'(lat), 64'(MUL_LAT));
      chk("mult_busy_cycles", 64'(bc), 64'(MUL_BUSY));
      chk("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
      chk("mult_lo", 64'(bus.lo), 64'hFFFF_FFF1);
      tick();
      chk("done_pulse_len", 64'(bus.done), 64'd0);

      // DIVU 100 / 7 = 14 r 2
      issue(OP_DIVU, 32'd100, 32'd7);
      wait_done(lat, bc);
      chk("divu_lat", 64'(lat), 64'(DIV_LAT));
      chk("divu_lo", 64'(bus.lo), 64'd14);
      chk("divu_hi", 64'(bus.hi), 64'd2);
      tick();

      // DIV -7 / 2 = -3 r -1
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done(lat, bc);
      chk("div_neg_lo", 64'(bus.lo), 64'hFFFF_FFFD);
      chk("div_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);
      tick();

      // DIV overflow case
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(lat, bc);
      chk("div_ovf_lo", 64'(bus.lo), 64'h8000_0000);
      chk("div_ovf_hi", 64'(bus.hi), 64'd0);
      tick();

      // DIVU by zero skips CALC/FIX
      issue(OP_DIVU, 32'd9, 32'd0);
      wait_done(lat, bc);
      chk("div0_lat", 64'(lat), 64'd1);
      chk("div0_busy_cycles", 64'(bc), 64'd0);
      chk("div0_lo", 64'(bus.lo), 64'hFFFF_FFFF);
      chk("div0_hi", 64'(bus.hi), 64'd9);
      tick();

      // MTHI while idle
      bus.hi_we = 1'b1;
      bus.wdata = 32'hAA;
      tick();
      bus.hi_we = 1'b0;
      chk("mthi_idle", 64'(bus.hi), 64'hAA);

      // Flush mid-CALC, with an MTHI attempt while busy
      issue(OP_MULTU, 32'd3, 32'd4);
      tick();
      bus.start = 1'b0;
      chk("flush_busy_before", 64'(bus.busy), 64'd1);
      repeat (FLUSH_TICKS) tick();
      bus.flush = 1'b1;
      bus.hi_we = 1'b1;
      bus.wdata = 32'h55;
      tick();
      bus.flush = 1'b0;
      bus.hi_we = 1'b0;
      chk("flush_busy_after", 64'(bus.busy), 64'd0);
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) dcnt++;
         tick();
      end
      chk("flush_no_done", 64'(dcnt), 64'd0);
      chk("flush_hi_kept", 64'(bus.hi), 64'hAA);
      chk("flush_lo_kept", 64'(bus.lo), 64'hFFFF_FFFF);

      // MULTU 3 * 4 after the flush
      issue(OP_MULTU, 32'd3, 32'd4);
      wait_done(lat, bc);
      chk("multu_lo", 64'(bus.lo), 64'd12);
      chk("multu_hi", 64'(bus.hi), 64'd0);
      tick();

      // flush beats a simultaneous start
      issue(OP_MULTU, 32'd1, 32'd1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      bus.start = 1'b0;
      chk("flush_vs_start_busy", 64'(bus.busy), 64'd0);
      chk("flush_vs_start_done", 64'(bus.done), 64'd0);

      // MTHI in the start cycle lands, then the result overwrites it
      issue(OP_MULTU, 32'd2, 32'd3);
      bus.hi_we = 1'b1;
      bus.wdata = 32'h77;
      tick();
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      chk("mt_with_start_hi", 64'(bus.hi), 64'h77);
      chk("mt_with_start_busy", 64'(bus.busy), 64'd1);
      wait_rest(lat, bc);
      chk("mt_with_start_res_lo", 64'(bus.lo), 64'd6);
      chk("mt_with_start_res_hi", 64'(bus.hi), 64'd0);
      tick();

      // Back-to-back issue from DONE, with MTLO in the DONE cycle
      issue(OP_MULTU, 32'd6, 32'd7);
      wait_done(lat, bc);
      chk("b2b_first_lo", 64'(bus.lo), 64'd42);
      issue(OP_DIVU, 32'd50, 32'd5);
      bus.lo_we = 1'b1;
      bus.wdata = 32'h1234;
      tick();
      bus.start = 1'b0;
      bus.lo_we = 1'b0;
      chk("b2b_no_idle_busy", 64'(bus.busy), 64'd1);
      chk("b2b_mtlo_wins", 64'(bus.lo), 64'h1234);
      chk("b2b_hi_result", 64'(bus.hi), 64'd0);
      wait_rest(lat, bc);
      chk("b2b_lat", 64'(lat), 64'(DIV_LAT));
      chk("b2b_lo", 64'(bus.lo), 64'd10);
      chk("b2b_hi", 64'(bus.hi), 64'd0);
      tick();

      // MULTU 0xFFFFFFFF * 2
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
      wait_done(lat, bc);
      chk("multu_big_lat", 64'(lat), 64'(MUL_LAT));
      chk("multu_big_hi", 64'(bus.hi), 64'd1);
      chk("multu_big_lo", 64'(bus.lo), 64'hFFFF_FFFE);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
